// File: rtl/counter_bcd_seq.sv
// Up/down binary counter with load and saturate/wrap, plus a serial double-dabble BCD converter.
// Latency: count 1 cycle; bcd valid WIDTH+1 cycles after count settles.
// Backpressure: none; a conversion always runs to completion, and a stale result triggers a rerun.
module counter_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic [WIDTH-1:0]      v,
  input  logic                  up,
  input  logic                  sat,
  output logic [WIDTH-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  ovf
);

  localparam int ITW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ITW-1:0]   LAST_IT = ITW'(WIDTH - 1);
  localparam logic [ITW-1:0]   IT_ONE  = ITW'(1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    snap, last, snap_rot;
  logic [ITW-1:0]      iter;
  logic [4*DIGITS-1:0] work, adj, work_nxt;
  logic                at_limit, done;

  assign at_limit = up ? (count == MAXV) : (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (ld) begin
      count <= v;
      ovf   <= 1'b0;
    end else if (en) begin
      ovf <= at_limit;
      if (!at_limit) begin
        count <= up ? count + ONE : count - ONE;
      end else if (!sat) begin
        count <= up ? '0 : MAXV;
      end
    end else begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (count != last) state_nxt = CONV;
      CONV: begin
        if (iter == LAST_IT) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // snap rotates rather than shifts so it holds the captured value again after WIDTH steps
  always_comb begin
    adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
    work_nxt = (adj << 1) | {{(4*DIGITS-1){1'b0}}, snap[WIDTH-1]};
    snap_rot = {snap[WIDTH-2:0], snap[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      last <= '0;
      iter <= '0;
      work <= '0;
      bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == CONV) begin
            snap <= count;
            work <= '0;
            iter <= '0;
          end
        end
        CONV: begin
          work <= work_nxt;
          snap <= snap_rot;
          iter <= iter + IT_ONE;
          if (done) begin
            bcd  <= work_nxt;
            last <= snap_rot;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_valid = (state == IDLE) && (last == count);

endmodule

// File: tb/tb_counter_bcd_seq.sv
// Directed plus random stimulus for counter_bcd_seq (WIDTH=8, DIGITS=3) against a cycle-level
// reference model built from decimal arithmetic and a conversion-timeline counter.
module tb_counter_bcd_seq;

  logic        clk = 1'b0;
  logic        rst, en, ld, up, sat;
  logic [7:0]  v;
  logic [7:0]  count;
  logic [11:0] bcd;
  logic        bcd_valid, ovf;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_count, m_last, m_cap, m_rem;
  bit         m_ovf, m_busy;
  logic [11:0] m_bcd;

  counter_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .v(v), .up(up), .sat(sat),
    .count(count), .bcd(bcd), .bcd_valid(bcd_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int n);
    logic [3:0] d0, d1, d2;
    d0 = 4'(n % 10);
    d1 = 4'((n / 10) % 10);
    d2 = 4'((n / 100) % 10);
    return {d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_last = 0; m_cap = 0; m_rem = 0;
    m_ovf = 0; m_busy = 0; m_bcd = '0;
  endtask

  task automatic model_edge(input bit i_ld, i_en, i_up, i_sat, input int i_v);
    // converter samples the count as it was before this edge
    if (!m_busy) begin
      if (m_count != m_last) begin
        m_busy = 1; m_cap = m_count; m_rem = 8;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_bcd = to_bcd(m_cap); m_last = m_cap; m_busy = 0;
      end
    end
    if (i_ld) begin
      m_count = i_v; m_ovf = 0;
    end else if (i_en) begin
      if (i_up) begin
        if (m_count == 255) begin m_ovf = 1; m_count = i_sat ? 255 : 0; end
        else begin m_ovf = 0; m_count = m_count + 1; end
      end else begin
        if (m_count == 0) begin m_ovf = 1; m_count = i_sat ? 0 : 255; end
        else begin m_ovf = 0; m_count = m_count - 1; end
      end
    end else begin
      m_ovf = 0;
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("bcd", 32'(bcd), 32'(m_bcd));
    check("bcd_valid", 32'(bcd_valid), 32'((!m_busy) && (m_last == m_count)));
  endtask

  // called at a negedge: drive, take one rising edge, check at the following negedge
  task automatic cyc(input bit i_ld, i_en, i_up, i_sat, input int i_v);
    ld = i_ld; en = i_en; up = i_up; sat = i_sat; v = 8'(i_v);
    @(posedge clk);
    model_edge(i_ld, i_en, i_up, i_sat, i_v);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 0; ld = 0; up = 0; sat = 0; v = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();

    // quiet after reset: stays at zero, valid, no conversion
    idle(20);
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_valid", 32'(bcd_valid), 32'd1);

    // load 255: invalid for 9 cycles then 0x255
    cyc(1, 0, 0, 0, 255);
    check("ld255_count", 32'(count), 32'd255);
    idle(8);
    check("ld255_pending", 32'(bcd_valid), 32'd0);
    idle(1);
    check("ld255_bcd", 32'(bcd), 32'h255);
    check("ld255_valid", 32'(bcd_valid), 32'd1);

    // wrap and saturate at the top
    cyc(0, 1, 1, 0, 0);
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_ovf", 32'(ovf), 32'd1);
    idle(1);
    check("wrap_ovf_clear", 32'(ovf), 32'd0);
    cyc(1, 0, 0, 0, 255);
    idle(20);
    cyc(0, 1, 1, 1, 0);
    check("sat_top_count", 32'(count), 32'd255);
    check("sat_top_ovf", 32'(ovf), 32'd1);
    idle(20);

    // saturate at zero for three cycles, then load with enable suppresses ovf
    cyc(1, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 0);
      check("sat_bot_count", 32'(count), 32'd0);
      check("sat_bot_ovf", 32'(ovf), 32'd1);
    end
    cyc(1, 1, 0, 1, 5);
    check("ld_en_count", 32'(count), 32'd5);
    check("ld_en_ovf", 32'(ovf), 32'd0);
    idle(20);

    // count 0..30 continuously, then settle
    cyc(1, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 1, 0, 0);
      check("run_valid_low", 32'(bcd_valid), 32'd0);
    end
    idle(18);
    check("run_bcd", 32'(bcd), 32'h030);
    check("run_valid", 32'(bcd_valid), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
    end
    idle(20);
    check("rand_settle_valid", 32'(bcd_valid), 32'd1);

    // reset in the middle of a conversion of 200
    cyc(1, 0, 0, 0, 200);
    idle(5);
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'd0);
    check("arst_bcd", 32'(bcd), 32'h000);
    check("arst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("no_stale_200", 32'(bcd != 12'h200), 32'd1);
    end
    check("arst_valid", 32'(bcd_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_bcd_seq.md
COUNTER_BCD_SEQ -- requirements
Module: counter_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter DIGITS, default 3, BCD digit count; the integrator guarantees 10^DIGITS > 2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port ld  input  1  synchronous load of v.
REQ-007 SHALL have port v  input  WIDTH  preload value.
REQ-008 SHALL have port up  input  1  direction, 1 = increment, 0 = decrement.
REQ-009 SHALL have port sat  input  1  mode, 1 = saturate at limits, 0 = wrap.
REQ-010 SHALL have port count  output  WIDTH  binary counter value (registered).
REQ-011 SHALL have port bcd  output  4*DIGITS  last completed BCD conversion, digit 0 in bits [3:0].
REQ-012 SHALL have port bcd_valid  output  1  high when bcd equals decimal of current count.
REQ-013 SHALL have port ovf  output  1  registered one-cycle limit-hit pulse.

Function
REQ-014 Counter SHALL update each edge with priority: ld (count<=v) > en (step) > hold.
REQ-015 Step with up=1 SHALL give count+1; at 2^WIDTH-1 it SHALL become 0 if sat=0, stay at max if sat=1.
REQ-016 Step with up=0 SHALL give count-1; at 0 it SHALL become 2^WIDTH-1 if sat=0, stay 0 if sat=1.
REQ-017 ovf SHALL be high for exactly the cycle after a step attempted at a limit (either mode); ld SHALL never set ovf; ld with en SHALL suppress ovf.
REQ-018 Converter SHALL be an FSM with states IDLE and CONV plus registers snap (WIDTH), last (WIDTH), shift iteration counter, BCD work register.
REQ-019 In IDLE, if count != last, converter SHALL capture snap<=count, clear work register, go to CONV; otherwise stay IDLE.
REQ-020 Each CONV cycle SHALL perform one double-dabble step: add 3 to every work digit >= 5, then shift {work, snap} left by 1.
REQ-021 After exactly WIDTH CONV cycles, the final edge SHALL write bcd with the result, set last<=captured value, and return to IDLE.
REQ-022 Latency: count updated at edge t with no conversion in progress SHALL yield correct bcd and bcd_valid=1 after edge t+1+WIDTH.
REQ-023 bcd SHALL change only on the final CONV edge; it SHALL hold its previous value during conversion.
REQ-024 bcd_valid SHALL equal (state==IDLE) && (last==count), combinationally from registers.
REQ-025 count changing during CONV SHALL NOT abort the conversion; the stale result SHALL be written, and a new conversion SHALL start from IDLE on the next edge; worst-case settle after count stops is 2*(WIDTH+1) cycles.
REQ-026 Digits above the width needed for 2^WIDTH-1 SHALL read 0.

Reset
REQ-027 rst high SHALL asynchronously force count=0, ovf=0, bcd=0, last=0, state=IDLE, iteration counter=0, aborting any conversion.
REQ-028 After reset release with no stimulus, bcd_valid SHALL be 1 (last==count==0) and no conversion SHALL start.

Verification (WIDTH=8, DIGITS=3)
REQ-029 Reset, hold inputs low -> count=0x00, bcd=0x000, bcd_valid=1, ovf=0 for 20 cycles.
REQ-030 ld=1 v=255 for one cycle -> count=255 next edge, bcd_valid=0 for 9 cycles, then bcd=0x255, bcd_valid=1.
REQ-031 count=255, sat=0 up=1 en=1 one cycle -> count=0, ovf high one cycle; sat=1 same -> count stays 255, ovf high one cycle.
REQ-032 count=0, sat=1 up=0 en=1 three cycles -> count stays 0, ovf high three cycles; then ld=1 v=5 en=1 -> count=5, ovf=0.
REQ-033 en=1 up=1 from 0 for 30 cycles, then en=0 -> bcd_valid=0 during counting, within 18 cycles after stop bcd=0x030, bcd_valid=1; each intermediate bcd is a correct decimal of some earlier count.
REQ-034 ld v=200, assert rst 4 cycles into conversion -> immediately count=0, bcd=0x000; after release bcd_valid=1, no stale 0x200 ever appears.
